// File: rtl/result_streamer_if.sv
// Handshake bundle between the multiplier datapath, the result streamer and its consumer.
// slave is the streamer's view; master is the view of whoever drives results and accepts output.
interface result_streamer_if #(
    parameter int RW    = 24,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [RW-1:0] resultIn;
    logic          resultValid;
    logic [RW-1:0] outData;
    logic          outValid;
    logic          outReady;
    logic          outLast;
    logic          frameDone;
    logic          overflow;
    logic [LW-1:0] level;
    logic          busy;

    modport slave (
        input  resultIn, resultValid, outReady,
        output outData, outValid, outLast, frameDone, overflow, level, busy
    );

    modport master (
        output resultIn, resultValid, outReady,
        input  outData, outValid, outLast, frameDone, overflow, level, busy
    );
endinterface

// File: rtl/result_streamer.sv
// Show-ahead result buffer that frames matrix-product elements for a ready/valid consumer.
// Upstream cannot be stalled, so elements arriving into a full buffer are dropped and flagged.
module result_streamer #(
    parameter int RW    = 24,
    parameter int FRAME = 4,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    result_streamer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = (FRAME > 1) ? $clog2(FRAME) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        FINISH = 2'd2
    } state_t;

    logic [RW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [CW-1:0] in_cnt_q, in_cnt_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic          overflow_q, overflow_d;
    state_t        state_q, state_d;

    logic full;
    logic out_valid;
    logic out_last;
    logic rd_fire;
    logic wr_fire;

    assign full      = (level_q == LW'(DEPTH));
    assign out_valid = (level_q != '0);
    assign out_last  = out_valid && (out_cnt_q == CW'(FRAME - 1));
    assign rd_fire   = out_valid && bus.outReady;
    // A simultaneous read frees a slot, so a full buffer still accepts the incoming element.
    assign wr_fire   = bus.resultValid && (!full || rd_fire);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        in_cnt_d   = in_cnt_q;
        out_cnt_d  = out_cnt_q;
        overflow_d = overflow_q;

        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (in_cnt_q == CW'(FRAME - 1)) begin
                in_cnt_d = '0;
            end else begin
                in_cnt_d = in_cnt_q + CW'(1);
            end
        end else if (bus.resultValid) begin
            overflow_d = 1'b1;
        end

        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            if (out_last) begin
                out_cnt_d = '0;
            end else begin
                out_cnt_d = out_cnt_q + CW'(1);
            end
        end

        if (wr_fire && !rd_fire) begin
            level_d = level_q + LW'(1);
        end else if (rd_fire && !wr_fire) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is cleared on reset so outData reads back zero until the first write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_fire) begin
            mem_q[wr_ptr_q] <= bus.resultIn;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (wr_fire) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (rd_fire && out_last) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                // An element arriving here is the start of the next frame.
                state_d = wr_fire ? ACTIVE : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign bus.outData   = mem_q[rd_ptr_q];
    assign bus.outValid  = out_valid;
    assign bus.outLast   = out_last;
    assign bus.frameDone = (state_q == FINISH);
    assign bus.overflow  = overflow_q;
    assign bus.level     = level_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_result_streamer.sv
// Directed bench for result_streamer: each step drives one cycle of inputs, then checks
// the registered outputs 1 time unit after the rising edge against hand-computed values.
module tb_result_streamer;
    localparam int RW    = 24;
    localparam int FRAME = 4;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total  = 0;
    int   passed = 0;
    int   fd_pulses = 0;
    int   fd_start;

    result_streamer_if #(.RW(RW), .DEPTH(DEPTH)) bus ();

    result_streamer #(.RW(RW), .FRAME(FRAME), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.frameDone === 1'b1) fd_pulses <= fd_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic [RW-1:0] d, input logic r);
        bus.resultValid = v;
        bus.resultIn    = d;
        bus.outReady    = r;
        @(posedge clk);
        #1;
        $display("t=%0t rst=%0b v=%0b d=%0d r=%0b -> outData=%0d outValid=%0b outLast=%0b level=%0d frameDone=%0b busy=%0b ovf=%0b",
                 $time, rst, v, d, r, bus.outData, bus.outValid, bus.outLast, bus.level,
                 bus.frameDone, bus.busy, bus.overflow);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(1'b0, '0, 1'b0);
        rst = 1'b0;
    endtask

    initial begin
        bus.resultValid = 1'b0;
        bus.resultIn    = '0;
        bus.outReady    = 1'b0;

        // Reset state
        rst = 1'b1;
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);
        check("rst_level",     32'(bus.level), 0);
        check("rst_outValid",  32'(bus.outValid), 0);
        check("rst_outData",   32'(bus.outData), 0);
        check("rst_outLast",   32'(bus.outLast), 0);
        check("rst_busy",      32'(bus.busy), 0);
        check("rst_overflow",  32'(bus.overflow), 0);
        check("rst_frameDone", 32'(bus.frameDone), 0);
        rst = 1'b0;

        // Streaming frame 1,2,3,4 with consumer always ready
        step(1'b1, 24'd1, 1'b1);
        check("s_d1", 32'(bus.outData), 1);
        check("s_v1", 32'(bus.outValid), 1);
        check("s_busy1", 32'(bus.busy), 1);
        check("s_last1", 32'(bus.outLast), 0);
        step(1'b1, 24'd2, 1'b1);
        check("s_d2", 32'(bus.outData), 2);
        check("s_lvl2", 32'(bus.level), 1);
        step(1'b1, 24'd3, 1'b1);
        check("s_d3", 32'(bus.outData), 3);
        check("s_last3", 32'(bus.outLast), 0);
        step(1'b1, 24'd4, 1'b1);
        check("s_d4", 32'(bus.outData), 4);
        check("s_last4", 32'(bus.outLast), 1);
        step(1'b0, '0, 1'b1);
        check("s_fd", 32'(bus.frameDone), 1);
        check("s_fd_busy", 32'(bus.busy), 1);
        check("s_empty", 32'(bus.outValid), 0);
        step(1'b0, '0, 1'b0);
        check("s_fd_off", 32'(bus.frameDone), 0);
        check("s_idle", 32'(bus.busy), 0);

        // Fill while stalled, fifth element dropped
        step(1'b1, 24'd10, 1'b0);
        step(1'b1, 24'd20, 1'b0);
        step(1'b1, 24'd30, 1'b0);
        step(1'b1, 24'd40, 1'b0);
        check("o_full", 32'(bus.level), 4);
        check("o_no_ovf", 32'(bus.overflow), 0);
        step(1'b1, 24'd50, 1'b0);
        check("o_lvl", 32'(bus.level), 4);
        check("o_ovf", 32'(bus.overflow), 1);
        check("o_d10", 32'(bus.outData), 10);
        step(1'b0, '0, 1'b1);
        check("o_d20", 32'(bus.outData), 20);
        check("o_lvl3", 32'(bus.level), 3);
        step(1'b0, '0, 1'b1);
        check("o_d30", 32'(bus.outData), 30);
        step(1'b0, '0, 1'b1);
        check("o_d40", 32'(bus.outData), 40);
        check("o_last40", 32'(bus.outLast), 1);
        check("o_ovf_sticky", 32'(bus.overflow), 1);
        step(1'b0, '0, 1'b1);
        check("o_fd", 32'(bus.frameDone), 1);
        check("o_drained", 32'(bus.level), 0);
        step(1'b0, '0, 1'b0);
        check("o_ovf_hold", 32'(bus.overflow), 1);
        do_reset();
        check("o_ovf_clr", 32'(bus.overflow), 0);

        // Full buffer with simultaneous read and write
        step(1'b1, 24'd11, 1'b0);
        step(1'b1, 24'd12, 1'b0);
        step(1'b1, 24'd13, 1'b0);
        step(1'b1, 24'd14, 1'b0);
        check("f_full", 32'(bus.level), 4);
        step(1'b1, 24'd99, 1'b1);
        check("f_lvl", 32'(bus.level), 4);
        check("f_d12", 32'(bus.outData), 12);
        check("f_no_ovf", 32'(bus.overflow), 0);
        step(1'b0, '0, 1'b1);
        check("f_d13", 32'(bus.outData), 13);
        step(1'b0, '0, 1'b1);
        check("f_d14", 32'(bus.outData), 14);
        check("f_last14", 32'(bus.outLast), 1);
        step(1'b0, '0, 1'b1);
        check("f_d99", 32'(bus.outData), 99);
        check("f_last99", 32'(bus.outLast), 0);
        check("f_fd", 32'(bus.frameDone), 1);
        step(1'b0, '0, 1'b1);
        check("f_empty", 32'(bus.outValid), 0);
        do_reset();

        // Two frames across pointer wrap, consumer toggling
        fd_start = fd_pulses;
        step(1'b1, 24'd1, 1'b1);
        check("w_d1a", 32'(bus.outData), 1);
        step(1'b1, 24'd2, 1'b0);
        check("w_d1b", 32'(bus.outData), 1);
        check("w_lvl2", 32'(bus.level), 2);
        step(1'b1, 24'd3, 1'b1);
        check("w_d2a", 32'(bus.outData), 2);
        step(1'b1, 24'd4, 1'b0);
        check("w_lvl3", 32'(bus.level), 3);
        step(1'b0, '0, 1'b1);
        check("w_d3a", 32'(bus.outData), 3);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        check("w_d4", 32'(bus.outData), 4);
        check("w_last4", 32'(bus.outLast), 1);
        step(1'b1, 24'd5, 1'b1);
        check("w_d5", 32'(bus.outData), 5);
        check("w_fd1", 32'(bus.frameDone), 1);
        check("w_last5", 32'(bus.outLast), 0);
        step(1'b1, 24'd6, 1'b0);
        check("w_busy", 32'(bus.busy), 1);
        check("w_fd1_off", 32'(bus.frameDone), 0);
        step(1'b1, 24'd7, 1'b1);
        check("w_d6", 32'(bus.outData), 6);
        step(1'b1, 24'd8, 1'b0);
        check("w_lvl3b", 32'(bus.level), 3);
        step(1'b0, '0, 1'b1);
        check("w_d7", 32'(bus.outData), 7);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        check("w_d8", 32'(bus.outData), 8);
        check("w_last8", 32'(bus.outLast), 1);
        step(1'b0, '0, 1'b1);
        check("w_fd2", 32'(bus.frameDone), 1);
        step(1'b0, '0, 1'b0);
        check("w_idle", 32'(bus.busy), 0);
        check("w_pulses", 32'(fd_pulses - fd_start), 2);

        // Reset in the middle of a frame
        step(1'b1, 24'd100, 1'b0);
        step(1'b1, 24'd101, 1'b0);
        check("r_lvl2", 32'(bus.level), 2);
        rst = 1'b1;
        step(1'b1, 24'd55, 1'b0);
        rst = 1'b0;
        check("r_lvl0", 32'(bus.level), 0);
        check("r_valid0", 32'(bus.outValid), 0);
        check("r_busy0", 32'(bus.busy), 0);
        check("r_data0", 32'(bus.outData), 0);
        step(1'b1, 24'd7, 1'b1);
        check("r_d7", 32'(bus.outData), 7);
        step(1'b1, 24'd8, 1'b1);
        check("r_d8", 32'(bus.outData), 8);
        step(1'b1, 24'd9, 1'b1);
        check("r_d9", 32'(bus.outData), 9);
        check("r_last9", 32'(bus.outLast), 0);
        step(1'b1, 24'd10, 1'b1);
        check("r_d10", 32'(bus.outData), 10);
        check("r_last10", 32'(bus.outLast), 1);
        step(1'b0, '0, 1'b1);
        check("r_fd", 32'(bus.frameDone), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
